// File: rtl/pwm_capture.sv
// pwm_capture: measures PWM period and high time over N periods; optional glitch filter via PWM_CAPTURE_GLITCH_FILTER_EN
module pwm_capture #(
  parameter int WIDTH      = 16,
  parameter int DONE_LEN   = 10,
  parameter int FILTER_LEN = 3
) (
  input  logic             iCLK,
  input  logic             iRSTn,
  input  logic             iPWM,
  input  logic             iStart,
  input  logic [1:0]       iAddr,
  input  logic             iWe,
  input  logic [WIDTH-1:0] iWdata,
  output logic [WIDTH-1:0] oRdata,
  output logic             oCapture_Done,
  output logic             oBusy
);
  typedef enum logic [2:0] {IDLE, ARM, HIGH, LOW, DONE} state_t;
  localparam int DW = $clog2(DONE_LEN + 1);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  if (FILTER_LEN < 1 || DONE_LEN < 1 || WIDTH < 4) begin : g_bad_param
    $error("pwm_capture: FILTER_LEN and DONE_LEN must be >= 1, WIDTH >= 4");
  end
  state_t state_q, state_d;
  logic sync1_q, sync2_q, lvl, lvl_dly_q, rise, fall;
  logic [WIDTH-1:0] cnt_q, cnt_d, per_q, per_d, high_q, high_d, tgt_q, tgt_d;
  logic [WIDTH-1:0] tlat_q, tlat_d, pdone_q, pdone_d, rdata_q, rdata_d;
  logic valid_q, valid_d, ovf_q, ovf_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  // two-flop synchronizer for the async line, plus a delayed copy of the edge-detect level
  always_ff @(posedge iCLK or negedge iRSTn)
    if (!iRSTn) {sync1_q, sync2_q, lvl_dly_q} <= '0;
    else {sync1_q, sync2_q, lvl_dly_q} <= {iPWM, sync1_q, lvl};
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);
  logic filt_q;
  logic [FW-1:0] fcnt_q;
  // accept a new level only after it has held for FILTER_LEN consecutive cycles
  always_ff @(posedge iCLK or negedge iRSTn)
    if (!iRSTn) begin
      filt_q <= 1'b0;
      fcnt_q <= '0;
    end else if (sync2_q == filt_q) fcnt_q <= '0;
    else if (fcnt_q == FW'(FILTER_LEN - 1)) begin
      filt_q <= sync2_q;
      fcnt_q <= '0;
    end else fcnt_q <= fcnt_q + FW'(1);
  assign lvl = filt_q;
`else
  assign lvl = sync2_q;
`endif
  assign rise = lvl & ~lvl_dly_q;
  assign fall = ~lvl & lvl_dly_q;
  assign oBusy = state_q inside {ARM, HIGH, LOW};
  assign oCapture_Done = state_q == DONE;
  assign oRdata = rdata_q;
  // next-state: measurement FSM, target register and read mux
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    high_d  = high_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    pdone_d = pdone_q;
    tlat_d  = tlat_q;
    dcnt_d  = '0;
    tgt_d   = (iWe && iAddr == 2'd2) ? (iWdata == '0 ? ONE : iWdata) : tgt_q;
    rdata_d = iAddr == 2'd0 ? per_q :
              iAddr == 2'd1 ? high_q :
              iAddr == 2'd2 ? tgt_q : {{(WIDTH-3){1'b0}}, ovf_q, oBusy, valid_q};
    case (state_q)
      IDLE: if (iStart) begin
        state_d = ARM;
        cnt_d   = '0;
        per_d   = '0;
        high_d  = '0;
        valid_d = 1'b0;
        ovf_d   = 1'b0;
        pdone_d = '0;
        tlat_d  = tgt_q;
      end
      ARM, HIGH, LOW: begin
        cnt_d = cnt_q + ONE;
        if (cnt_q == CNT_MAX) begin
          ovf_d   = 1'b1;
          state_d = DONE;
        end else if (state_q == ARM && rise) begin
          cnt_d   = ONE;
          state_d = HIGH;
        end else if (state_q == HIGH && fall) begin
          high_d  = cnt_q;
          state_d = LOW;
        end else if (state_q == LOW && rise) begin
          per_d   = cnt_q;
          valid_d = 1'b1;
          pdone_d = pdone_q + ONE;
          cnt_d   = ONE;
          state_d = (pdone_q + ONE == tlat_q) ? DONE : HIGH;
        end
      end
      DONE: begin
        dcnt_d = dcnt_q + DW'(1);
        if (dcnt_q == DW'(DONE_LEN - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers
  always_ff @(posedge iCLK or negedge iRSTn)
    if (!iRSTn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      per_q   <= '0;
      high_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      pdone_q <= '0;
      tlat_q  <= '0;
      dcnt_q  <= '0;
      tgt_q   <= ONE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      high_q  <= high_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      pdone_q <= pdone_d;
      tlat_q  <= tlat_d;
      dcnt_q  <= dcnt_d;
      tgt_q   <= tgt_d;
      rdata_q <= rdata_d;
    end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed and randomized checks of pwm_capture against an edge-timestamp reference model
module tb_pwm_capture;
  localparam int W = 10, DL = 10, FL = 3;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif
  logic iCLK = 1'b0, iRSTn = 1'b0, iPWM = 1'b0, iStart = 1'b0, iWe = 1'b0;
  logic [1:0] iAddr = 2'd0;
  logic [W-1:0] iWdata = '0;
  logic [W-1:0] oRdata;
  logic oCapture_Done, oBusy;
  int checks = 0, failures = 0, cyc = 0;
  int wh = 4, wl = 4, phase = 0, glitch = -1;
  bit wave_on = 1'b0, rec = 1'b0;
  bit lv[$];
  int t0, tdone, m_per, m_hi, m_n, m_fin, r_per, r_hi;

  always #5 iCLK = ~iCLK;

  pwm_capture #(.WIDTH(W), .DONE_LEN(DL), .FILTER_LEN(FL)) dut (
    .iCLK(iCLK), .iRSTn(iRSTn), .iPWM(iPWM), .iStart(iStart), .iAddr(iAddr),
    .iWe(iWe), .iWdata(iWdata), .oRdata(oRdata), .oCapture_Done(oCapture_Done), .oBusy(oBusy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  // one clock: step past the edge, then drive the next line level
  task automatic tick();
    @(posedge iCLK);
    #1;
    cyc++;
    if (wave_on) phase = (phase + 1) % (wh + wl);
    iPWM = wave_on && phase < wh && phase != glitch;
    if (rec) lv.push_back(iPWM);
  endtask

  task automatic rd(input logic [1:0] a, output logic [W-1:0] d);
    iAddr = a;
    tick();
    d = oRdata;
  endtask

  task automatic wr(input logic [W-1:0] v);
    iAddr = 2'd2;
    iWe = 1'b1;
    iWdata = v;
    tick();
    iWe = 1'b0;
  endtask

  // hold the line low, pulse start, then launch the wave at the beginning of its low phase
  task automatic arm(input int h, input int l, input int g);
    wave_on = 1'b0;
    repeat (6) tick();
    iStart = 1'b1;
    tick();
    t0 = cyc;
    iStart = 1'b0;
    wh = h;
    wl = l;
    glitch = g;
    phase = h - 1;
    wave_on = 1'b1;
    lv.delete();
    rec = 1'b1;
  endtask

  task automatic wait_done(input int budget, output bit ok, output int len);
    int el;
    ok = 1'b0;
    el = 0;
    len = 0;
    while (el < budget && !ok) begin
      tick();
      el++;
      ok = (oCapture_Done === 1'b1);
    end
    tdone = cyc;
    rec = 1'b0;
    while (oCapture_Done === 1'b1 && len < 4 * DL) begin
      len++;
      tick();
    end
  endtask

  // reference: accepted level per cycle, rise/fall timestamps, then periods from rise-to-rise
  task automatic model(input int tgt);
    int rs[$], fs[$];
    bit a, p;
    int run;
    a = 1'b0;
    run = 0;
    foreach (lv[i]) begin
      p = a;
      if (FILT) begin
        if (lv[i] != a) begin
          run++;
          if (run == FL) begin
            a = lv[i];
            run = 0;
          end
        end else run = 0;
      end else a = lv[i];
      if (a && !p) rs.push_back(i);
      if (!a && p) fs.push_back(i);
    end
    m_per = 0;
    m_hi = 0;
    m_n = 0;
    m_fin = -1;
    for (int k = 0; k < tgt && k + 1 < rs.size(); k++) begin
      m_per = rs[k+1] - rs[k];
      foreach (fs[j]) if (fs[j] > rs[k] && fs[j] < rs[k+1]) m_hi = fs[j] - rs[k];
      m_n++;
      m_fin = rs[k+1];
    end
  endtask

  task automatic finish_run(input string tg, input int tgt, input bit ok, input int len);
    logic [W-1:0] d;
    model(tgt);
    chk({tg, "_seen"}, ok, 1);
    chk({tg, "_len"}, len, DL);
    chk({tg, "_busy"}, oBusy, 0);
    rd(2'd0, d);
    r_per = d;
    chk({tg, "_per"}, d, m_per);
    rd(2'd1, d);
    r_hi = d;
    chk({tg, "_hi"}, d, m_hi);
    rd(2'd3, d);
    chk({tg, "_stat"}, d, {(m_n < tgt), 1'b0, (m_n > 0)});
    if (m_n == tgt) chk({tg, "_time"}, (tdone - t0 >= m_fin + 1) && (tdone - t0 <= m_fin + 12), 1);
  endtask

  initial begin
    logic [W-1:0] d;
    bit ok;
    int len, dn, hh, lo, h, l, t, ep, eh;
    repeat (3) tick();
    chk("rst_rdata", oRdata, 0);
    chk("rst_done", oCapture_Done, 0);
    chk("rst_busy", oBusy, 0);
    iRSTn = 1'b1;
    tick();
    rd(2'd2, d);
    chk("rst_tgt", d, 1);
    rd(2'd3, d);
    chk("rst_stat", d, 0);
    // target 4, H=3/L=5
    wr(4);
    arm(3, 5, -1);
    chk("t1_busy_run", oBusy, 1);
    wait_done(400, ok, len);
    finish_run("t1", 4, ok, len);
    chk("t1_per_c", r_per, 8);
    chk("t1_hi_c", r_hi, 3);
    // write 0 stores 1; minimum-width wave
    wr(0);
    rd(2'd2, d);
    chk("t2_tgt0", d, 1);
    hh = FILT ? FL + 1 : 2;
    arm(hh, hh, -1);
    wait_done(200, ok, len);
    finish_run("t2", 1, ok, len);
    chk("t2_per_c", r_per, 2 * hh);
    chk("t2_hi_c", r_hi, hh);
    // stuck-low line times out
    arm(4, 4, -1);
    wave_on = 1'b0;
    wait_done(1200, ok, len);
    chk("t3_time", (tdone - t0 >= (1 << W) - 1) && (tdone - t0 <= (1 << W) + 4), 1);
    finish_run("t3", 1, ok, len);
    // restart and target write during a run do not disturb it
    wr(3);
    arm(4, 4, -1);
    repeat (10) tick();
    iStart = 1'b1;
    iWe = 1'b1;
    iAddr = 2'd2;
    iWdata = 7;
    tick();
    iStart = 1'b0;
    iWe = 1'b0;
    wait_done(300, ok, len);
    finish_run("t4a", 3, ok, len);
    rd(2'd2, d);
    chk("t4_tgt7", d, 7);
    arm(4, 4, -1);
    wait_done(300, ok, len);
    finish_run("t4b", 7, ok, len);
    // start held through DONE re-arms at once
    wr(1);
    arm(3, 3, -1);
    iStart = 1'b1;
    wait_done(200, ok, len);
    chk("rearm_seen", ok, 1);
    tick();
    chk("rearm_busy", oBusy, 1);
    iStart = 1'b0;
    wait_done(300, ok, len);
    chk("rearm_done", ok, 1);
    // reset while measuring the high phase
    wr(5);
    arm(6, 6, -1);
    for (int i = 0; i < 100 && !(phase == 4 && cyc - t0 > 8); i++) tick();
    chk("t5_busy_pre", oBusy, 1);
    iRSTn = 1'b0;
    #1;
    chk("t5_rdata", oRdata, 0);
    chk("t5_busy", oBusy, 0);
    chk("t5_done", oCapture_Done, 0);
    repeat (2) tick();
    iRSTn = 1'b1;
    rec = 1'b0;
    dn = 0;
    repeat (30) begin
      tick();
      if (oCapture_Done) dn++;
    end
    chk("t5_nodone", dn, 0);
    rd(2'd0, d);
    chk("t5_per0", d, 0);
    rd(2'd2, d);
    chk("t5_tgt1", d, 1);
    rd(2'd3, d);
    chk("t5_stat0", d, 0);
    arm(6, 6, -1);
    wait_done(200, ok, len);
    finish_run("t5r", 1, ok, len);
    chk("t5_per_c", r_per, 12);
    // one-cycle low glitch inside the high phase
    ep = FILT ? 12 : 4;
    eh = FILT ? 6 : 3;
    arm(6, 6, 3);
    wait_done(200, ok, len);
    finish_run("t6", 1, ok, len);
    chk("t6_per_c", r_per, ep);
    chk("t6_hi_c", r_hi, eh);
    // randomized waves and targets
    lo = FILT ? FL + 1 : 2;
    for (int n = 0; n < 8; n++) begin
      h = $urandom_range(10, lo);
      l = $urandom_range(10, lo);
      t = $urandom_range(4, 1);
      wr(W'(t));
      arm(h, l, -1);
      wait_done((t + 2) * (h + l) + 50, ok, len);
      finish_run("rnd", t, ok, len);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
PWM measurement block; the receive-side counterpart of the team's PWM timer. Samples an external PWM line and measures period and high time, in iCLK cycles, over a programmed number of periods. Results and status are read through a small register port; completion is flagged with a multi-cycle done strobe. Sits beside the timer on the same register bus, e.g. for loopback checking of timer output.

Parameters:
WIDTH, 16, width of counters, result registers and data bus
DONE_LEN, 10, number of cycles oCapture_Done is held high
FILTER_LEN, 3, glitch-filter stability length in cycles (used only with the optional feature)

Ports:
iCLK  input  1  clock
iRSTn  input  1  asynchronous active-low reset
iPWM  input  1  PWM line under measurement, asynchronous to iCLK
iStart  input  1  arm capture (level, sampled each cycle)
iAddr  input  2  register address
iWe  input  1  write enable; only address 2 is writable
iWdata  input  WIDTH  write data
oRdata  output  WIDTH  registered read data
oCapture_Done  output  1  capture-complete strobe
oBusy  output  1  high from arm until DONE is entered

Behaviour:
- Reset: iRSTn asynchronous, active-low; clock iCLK. All registers, synchronizer flops and outputs go to 0; FSM goes to IDLE; target register resets to 1.
- iPWM passes through a 2-flop synchronizer; edges are detected on the synchronized signal. Edge detection latency is fixed, so it cancels in all measured intervals.
- Contract: for a stable wave of H high and L low cycles, period = H+L and high = H, exactly, for H>=2 and L>=2.
- Register map:
  - addr0: last period, read-only.
  - addr1: last high time, read-only.
  - addr2: target period count, read/write; a write of 0 stores 1.
  - addr3: status {zeros, overflow[2], busy[1], valid[0]}.
  - oRdata updates on the clock after iAddr is presented (1-cycle latency) and updates every cycle.
  - Writes to addresses 0, 1 and 3 are ignored.
- FSM states: IDLE, ARM, HIGH, LOW, DONE.
  - IDLE: iStart=1 -> ARM. On entry to ARM, clear period, high, valid, overflow and periods-done, and latch the target register. oBusy=1 in ARM, HIGH and LOW.
  - ARM: wait for a rising edge -> HIGH, clear the interval counter.
  - HIGH: on a falling edge, capture the high time -> LOW.
  - LOW: on a rising edge:
    - capture the period, set valid, increment periods-done, clear the counter;
    - if periods-done equals the latched target -> DONE, else -> HIGH.
  - DONE: oCapture_Done=1 for exactly DONE_LEN cycles, then -> IDLE. Results persist until the next arm.
- Timeout: if the interval counter reaches 2^WIDTH-1 in ARM, HIGH or LOW, set overflow and go to DONE. Captured values from earlier complete periods are retained.
- Simultaneous events:
  - iStart while not in IDLE is ignored.
  - A target write during capture does not affect the current run.
  - iStart held high in IDLE after DONE re-arms immediately.
- Reset mid-capture: immediate return to IDLE with all state cleared; no done strobe.

Optional Feature:
PWM_CAPTURE_GLITCH_FILTER_EN
- Defined: after the synchronizer, a level change is accepted only once the synchronized input has held the new value for FILTER_LEN consecutive cycles. Pulses shorter than FILTER_LEN cycles are ignored. The measurement contract holds for H,L >= FILTER_LEN+1, with a constant added latency.
- Undefined: no filter; every synchronized transition is an edge.

Test Plan:
1. Target=4, iPWM H=3/L=5 repeating, pulse iStart -> after 4 periods: addr0=8, addr1=3, addr3=0b001; oCapture_Done high exactly 10 cycles; oBusy low after.
2. Target write 0, then read addr2 -> 1; capture with H=2/L=2 -> addr0=4, addr1=2 after the first full period.
3. iPWM stuck low after iStart -> DONE after 65535 cycles, addr3 bit2=1, bit0=0, done strobe 10 cycles.
4. Mid-capture: iStart re-pulse and write of addr2=7 -> current run finishes at the original target. Next run uses 7.
5. Assert iRSTn=0 during HIGH -> all outputs 0, IDLE, no done strobe. Re-arm works normally.
6. Macro defined, FILTER_LEN=3: H=6/L=6 wave with 1-cycle low glitch inside high -> addr0=12, addr1=6. Without the macro, the same stimulus yields a short high time.
